// File: rtl/trig_pkg.sv
// trig_pkg: shared state encoding, default widths and pointer helper for the trigger sample buffer
package trig_pkg;
  localparam int DATA_W_DEF = 19;
  localparam int ADDR_W_DEF = 10;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2,
    READ    = 2'd3
  } state_e;
  function automatic logic [15:0] next_ptr(input logic [15:0] ptr, input int addr_w);
    return (ptr + 16'd1) & 16'((32'd1 << addr_w) - 32'd1);
  endfunction
endpackage

// File: rtl/trig_skid_buf.sv
// trig_skid_buf: 2-entry valid/ready register slice carrying {last, data}
module trig_skid_buf #(
  parameter int DATA_W = 19
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DATA_W:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DATA_W:0] out_data
);
  logic out_v_q, out_v_d, sk_v_q, sk_v_d;
  logic [DATA_W:0] out_data_q, out_data_d, sk_data_q, sk_data_d;
  always_comb begin
    out_v_d    = out_v_q;
    out_data_d = out_data_q;
    sk_v_d     = sk_v_q;
    sk_data_d  = sk_data_q;
    if (out_ready || !out_v_q) begin
      out_v_d    = sk_v_q || in_valid;
      out_data_d = sk_v_q ? sk_data_q : (in_valid ? in_data : out_data_q);
      sk_v_d     = 1'b0;
    end else if (in_valid && !sk_v_q) begin
      sk_v_d    = 1'b1;
      sk_data_d = in_data;
    end
    if (flush) begin
      out_v_d = 1'b0;
      sk_v_d  = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_v_q    <= 1'b0;
      sk_v_q     <= 1'b0;
      out_data_q <= '0;
      sk_data_q  <= '0;
    end else begin
      out_v_q    <= out_v_d;
      sk_v_q     <= sk_v_d;
      out_data_q <= out_data_d;
      sk_data_q  <= sk_data_d;
    end
  end
  assign in_ready  = !sk_v_q;
  assign out_valid = out_v_q;
  assign out_data  = out_data_q;
endmodule

// File: rtl/trig_sample_buffer.sv
// trig_sample_buffer: captures probe samples from the trigger node and replays the window oldest-first
module trig_sample_buffer
  import trig_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              trig_clk,
  input  logic              trig_rst,
  input  logic              arm,
  input  logic [DATA_W-1:0] smp_din,
  input  logic              wt_ce,
  input  logic              wt_en,
  input  logic [15:0]       wt_addr,
  input  logic              stop_flag,
  input  logic [15:0]       stop_addr,
  input  logic              rd_start,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic              wrapped,
  output logic [1:0]        state_o
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW = ADDR_W + 1;
  logic [DATA_W-1:0] mem [DEPTH];
  state_e state_q, state_d;
  logic wrapped_q, wrapped_d, pend_q, pend_d, pend_last_q, pend_last_d;
  logic [ADDR_W-1:0] stop_ptr_q, stop_ptr_d, fetch_ptr_q, fetch_ptr_d, waddr;
  logic [CW-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] mem_rd_q;
  logic [DATA_W:0] sk_out;
  logic [1:0] occ;
  logic wr_en, issue, pop, in_ready, unused_hi;
  assign unused_hi = ^{wt_addr[15:ADDR_W], stop_addr[15:ADDR_W]};
  assign waddr = wt_addr[ADDR_W-1:0];
  assign wr_en = state_q == CAPTURE && wt_ce && wt_en;
  assign pop   = rd_valid && rd_ready;
  // words in flight or buffered must never exceed the two skid slots
  assign occ   = 2'(rd_valid) + 2'(!in_ready) + 2'(pend_q);
  assign issue = state_q == READ && !arm && rem_q != '0 && occ < (pop ? 2'd3 : 2'd2);
  always_comb begin
    state_d     = state_q;
    wrapped_d   = wrapped_q;
    stop_ptr_d  = stop_ptr_q;
    fetch_ptr_d = issue ? ADDR_W'(next_ptr(16'(fetch_ptr_q), ADDR_W)) : fetch_ptr_q;
    rem_d       = issue ? rem_q - 1'b1 : rem_q;
    pend_d      = issue;
    pend_last_d = issue ? rem_q == CW'(1) : pend_last_q;
    if (arm) begin
      state_d   = CAPTURE;
      wrapped_d = 1'b0;
      rem_d     = '0;
      pend_d    = 1'b0;
    end else begin
      unique case (state_q)
        CAPTURE: begin
          if (wr_en && waddr == ADDR_W'(DEPTH - 1)) wrapped_d = 1'b1;
          if (stop_flag) begin
            stop_ptr_d = stop_addr[ADDR_W-1:0];
            state_d    = DONE;
          end
        end
        DONE: begin
          if (rd_start) begin
            state_d     = READ;
            fetch_ptr_d = wrapped_q ? ADDR_W'(next_ptr(16'(stop_ptr_q), ADDR_W)) : '0;
            rem_d       = wrapped_q ? CW'(DEPTH) : {1'b0, stop_ptr_q} + 1'b1;
          end
        end
        READ: if (pop && rd_last) state_d = DONE;
        default: ;
      endcase
    end
  end
  always_ff @(posedge trig_clk) begin
    if (wr_en) mem[waddr] <= smp_din;
    if (issue) mem_rd_q <= mem[fetch_ptr_q];
  end
  always_ff @(posedge trig_clk) begin
    if (trig_rst) begin
      state_q     <= IDLE;
      wrapped_q   <= 1'b0;
      stop_ptr_q  <= '0;
      fetch_ptr_q <= '0;
      rem_q       <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wrapped_q   <= wrapped_d;
      stop_ptr_q  <= stop_ptr_d;
      fetch_ptr_q <= fetch_ptr_d;
      rem_q       <= rem_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
    end
  end
  trig_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clk      (trig_clk),
    .rst      (trig_rst),
    .flush    (arm),
    .in_valid (pend_q),
    .in_ready (in_ready),
    .in_data  ({pend_last_q, mem_rd_q}),
    .out_valid(rd_valid),
    .out_ready(rd_ready),
    .out_data (sk_out)
  );
  assign rd_data = sk_out[DATA_W-1:0];
  assign rd_last = sk_out[DATA_W];
  assign wrapped = wrapped_q;
  assign state_o = state_q;
endmodule

// File: tb/tb_trig_sample_buffer.sv
// tb_trig_sample_buffer: directed capture/replay sequence with immediate-assertion checks
module tb_trig_sample_buffer;
  localparam int DATA_W = 19;
  logic trig_clk = 0, trig_rst = 1, arm = 0, wt_ce = 0, wt_en = 0, stop_flag = 0, rd_start = 0, rd_ready = 0;
  logic [DATA_W-1:0] smp_din = '0;
  logic [15:0] wt_addr = '0, stop_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic rd_valid, rd_last, wrapped;
  logic [1:0] state_o;
  int vectors = 0, miscompares = 0;
  logic [DATA_W-1:0] got[$];
  bit lasts[$];
  int first_c, last_c, stall_bad, nlast, bad;
  bit done;
  always #5 trig_clk = ~trig_clk;
  trig_sample_buffer dut (
    .trig_clk (trig_clk),
    .trig_rst (trig_rst),
    .arm      (arm),
    .smp_din  (smp_din),
    .wt_ce    (wt_ce),
    .wt_en    (wt_en),
    .wt_addr  (wt_addr),
    .stop_flag(stop_flag),
    .stop_addr(stop_addr),
    .rd_start (rd_start),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_last  (rd_last),
    .wrapped  (wrapped),
    .state_o  (state_o)
  );
  task automatic tick;
    @(posedge trig_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input int a, input int d);
    wt_ce = 1; wt_en = 1; wt_addr = 16'(a); smp_din = DATA_W'(d);
    tick;
    wt_ce = 0; wt_en = 0;
  endtask
  task automatic stop_at(input int sa);
    stop_flag = 1; stop_addr = 16'(sa);
    tick;
    stop_flag = 0;
  endtask
  task automatic do_arm;
    arm = 1;
    tick;
    arm = 0;
  endtask
  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1; max_hs 0 means run to rd_last
  task automatic replay(input int mode, input int max_hs, input int budget);
    bit prev_stall = 0;
    logic [DATA_W-1:0] prev_data = '0;
    got.delete(); lasts.delete();
    first_c = -1; last_c = -1; stall_bad = 0; done = 0; nlast = 0;
    rd_start = 1;
    tick;
    rd_start = 0;
    for (int c = 0; c < budget && !done; c++) begin
      rd_ready = (mode == 0) ? 1'b1 : (c % 4 == 0 || c % 4 == 3);
      if (prev_stall && (rd_valid !== 1'b1 || rd_data !== prev_data)) stall_bad++;
      if (rd_valid && first_c < 0) first_c = c;
      if (rd_valid && rd_ready) begin
        got.push_back(rd_data);
        lasts.push_back(rd_last);
        if (rd_last) nlast++;
        last_c = c;
        if (rd_last || got.size() == max_hs) done = 1;
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data = rd_data;
      tick;
    end
    rd_ready = 0;
  endtask
  initial begin
    tick; tick;
    chk("rst state", 32'(state_o), 0);
    chk("rst valid", 32'(rd_valid), 0);
    chk("rst last", 32'(rd_last), 0);
    chk("rst data", 32'(rd_data), 0);
    chk("rst wrapped", 32'(wrapped), 0);
    trig_rst = 0;
    rd_start = 1; tick; rd_start = 0; tick; tick;
    chk("idle rd_start state", 32'(state_o), 0);
    chk("idle rd_start valid", 32'(rd_valid), 0);
    // scenario 1: non-wrapped capture
    do_arm;
    chk("s1 armed", 32'(state_o), 1);
    for (int a = 0; a < 10; a++) wr(a, 'h100 + a);
    stop_at(9);
    chk("s1 done", 32'(state_o), 2);
    replay(0, 0, 40);
    chk("s1 finished", 32'(done), 1);
    chk("s1 count", 32'(got.size()), 10);
    for (int i = 0; i < 10; i++) chk($sformatf("s1 word%0d", i), 32'(got[i]), 32'('h100 + i));
    chk("s1 nlast", 32'(nlast), 1);
    chk("s1 last flag", 32'(lasts[9]), 1);
    chk("s1 latency", 32'(first_c >= 0 && first_c <= 2), 1);
    chk("s1 back-to-back", 32'(last_c - first_c), 9);
    chk("s1 wrapped", 32'(wrapped), 0);
    chk("s1 state after", 32'(state_o), 2);
    chk("s1 valid drops", 32'(rd_valid), 0);
    // scenario 3: backpressure on the same capture
    replay(1, 0, 80);
    chk("s3 finished", 32'(done), 1);
    chk("s3 count", 32'(got.size()), 10);
    bad = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== DATA_W'('h100 + i)) bad++;
    chk("s3 order", 32'(bad), 0);
    chk("s3 stall stable", 32'(stall_bad), 0);
    chk("s3 nlast", 32'(nlast), 1);
    chk("s3 state after", 32'(state_o), 2);
    // scenario 2: wrapped capture
    do_arm;
    for (int n = 0; n < 1124; n++) wr(n % 1024, n);
    chk("s2 wrapped set", 32'(wrapped), 1);
    stop_at(99);
    chk("s2 done", 32'(state_o), 2);
    replay(0, 0, 1100);
    chk("s2 finished", 32'(done), 1);
    chk("s2 count", 32'(got.size()), 1024);
    bad = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== DATA_W'(100 + i)) bad++;
    chk("s2 words", 32'(bad), 0);
    chk("s2 first", 32'(got[0]), 100);
    chk("s2 lastword", 32'(got[1023]), 1123);
    chk("s2 last flag", 32'(lasts[1023]), 1);
    chk("s2 nlast", 32'(nlast), 1);
    chk("s2 wrapped", 32'(wrapped), 1);
    // scenario 5: abort after 3 handshakes
    replay(0, 3, 20);
    chk("s5 handshakes", 32'(got.size()), 3);
    chk("s5 word2", 32'(got[2]), 102);
    rd_ready = 1; arm = 1;
    tick;
    arm = 0; rd_ready = 0;
    chk("s5 valid", 32'(rd_valid), 0);
    chk("s5 state", 32'(state_o), 1);
    chk("s5 wrapped", 32'(wrapped), 0);
    // scenario 4: write coinciding with stop
    for (int a = 0; a < 5; a++) wr(a, 'h200 + a);
    stop_flag = 1; stop_addr = 16'd5;
    wr(5, 'h0AA);
    stop_flag = 0;
    chk("s4 done", 32'(state_o), 2);
    replay(0, 0, 30);
    chk("s4 count", 32'(got.size()), 6);
    chk("s4 first", 32'(got[0]), 'h200);
    chk("s4 lastword", 32'(got[5]), 'h0AA);
    chk("s4 last flag", 32'(lasts[5]), 1);
    // scenario 6: reset mid-capture
    do_arm;
    wr(1023, 'h55);
    chk("s6 wrapped pre", 32'(wrapped), 1);
    chk("s6 capture", 32'(state_o), 1);
    trig_rst = 1;
    tick;
    trig_rst = 0;
    chk("s6 state", 32'(state_o), 0);
    chk("s6 valid", 32'(rd_valid), 0);
    chk("s6 wrapped", 32'(wrapped), 0);
    rd_start = 1; tick; rd_start = 0; tick; tick;
    chk("s6 rd_start ignored", 32'(state_o), 0);
    chk("s6 no data", 32'(rd_valid), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/trig_sample_buffer.md
Name: trig_sample_buffer

Overview:
- Capture-memory stage directly downstream of the trigger node.
- Stores probe samples at the write address and strobes the trigger node produces, latches the stop address when the trigger node reports stop, then replays the captured window oldest-first on a valid/ready stream.
- The stream feeds the debug readout path. Everything runs in the trigger clock domain.

Parameters:
- DATA_W, 19, width of one probe sample (matches trigger node detector count).
- ADDR_W, 10, sample memory address bits.
- DEPTH, 2**ADDR_W, sample memory words (derived, not overridable).

Ports:
- trig_clk  in  1  sample clock.
- trig_rst  in  1  reset. Synchronous, active-high.
- arm  in  1  single-cycle pulse: clear capture status and start a new capture.
- smp_din  in  DATA_W  probe sample for the current cycle.
- wt_ce  in  1  memory enable from the trigger node.
- wt_en  in  1  write enable from the trigger node.
- wt_addr  in  16  write address from the trigger node. Only bits [ADDR_W-1:0] are used.
- stop_flag  in  1  trigger node capture-complete level.
- stop_addr  in  16  address of the last valid sample. Only bits [ADDR_W-1:0] are used.
- rd_start  in  1  single-cycle pulse: begin replay.
- rd_data  out  DATA_W  replayed sample.
- rd_valid  out  1  rd_data is valid.
- rd_ready  in  1  consumer accepts rd_data.
- rd_last  out  1  marks the final replayed word, qualified by rd_valid.
- wrapped  out  1  the buffer was written at address DEPTH-1 at least once in this capture.
- state_o  out  2  current FSM state (encoding below).

Behaviour:
- Reset values: state IDLE; rd_valid=0; rd_last=0; rd_data=0; wrapped=0; latched stop pointer=0; read counters=0. Memory contents are not reset.
- FSM encoding: IDLE=0, CAPTURE=1, DONE=2, READ=3.
- IDLE:
  - arm -> CAPTURE and clear wrapped.
  - rd_start is ignored.
- CAPTURE:
  - When wt_ce&wt_en=1: mem[wt_addr[ADDR_W-1:0]] <= smp_din on the same edge. No latency beyond the write edge.
  - A write to address DEPTH-1 sets wrapped on the next edge.
  - When stop_flag=1: latch stop_addr[ADDR_W-1:0] and go to DONE.
  - A write in the same cycle as stop_flag is still performed.
  - rd_start is ignored.
- DONE:
  - rd_start -> READ.
  - Start pointer = wrapped ? (stop_ptr+1) mod DEPTH : 0.
  - Word count = wrapped ? DEPTH : stop_ptr+1.
  - Writes are ignored.
- READ:
  - Synchronous-read memory (1-cycle read latency) feeds a 2-entry skid buffer.
  - The fetch pointer advances only when the skid buffer has space. Pointer wrap is natural modulo DEPTH.
  - First rd_valid appears no later than 2 cycles after the rd_start edge.
  - With rd_ready held high, throughput is one word per cycle.
  - rd_data and rd_valid stay stable while rd_valid&!rd_ready.
  - rd_last=1 exactly on word count-1.
  - The handshake on the last word -> DONE. rd_valid drops the next cycle.
  - Replay can be repeated from DONE.
- arm in any state: abort any replay, flush the skid buffer (rd_valid=0 next cycle), clear wrapped, go to CAPTURE.
- arm takes priority over stop_flag and rd_start in the same cycle.
- trig_rst asserted mid-capture or mid-replay: all state returns to reset values on the next edge.
- The trigger node must be configured with trig_len <= DEPTH. Higher wt_addr bits are silently dropped.

Decomposition:
- Shared package trig_pkg:
  - State encoding constants (IDLE/CAPTURE/DONE/READ).
  - ADDR_W/DATA_W defaults.
  - Function next_ptr(ptr) implementing modulo-DEPTH increment.
- Sub-module trig_skid_buf: 2-entry valid/ready register slice, parameter DATA_W, carries {rd_last, data}.
- The memory is inferred inside trig_sample_buffer: single write port, single synchronous read port.

Test Plan:
1. Non-wrapped capture.
   - Stimulus: arm; write addresses 0..9 with data 0x100+addr; stop_flag with stop_addr=9; rd_start; rd_ready=1.
   - Required response: 10 words 0x100..0x109 on consecutive cycles; rd_last only on 0x109; wrapped=0; state_o returns to 2.
2. Wrapped capture.
   - Stimulus: write addresses 0..1023 then 0..99 with data equal to the running count; stop_addr=99.
   - Required response: replay starts at address 100, yields 1024 words, first=100, last=1123 (truncated to DATA_W); wrapped=1.
3. Backpressure.
   - Stimulus: scenario 1 with rd_ready toggling 1,0,0,1 repeatedly.
   - Required response: no word lost or duplicated; rd_data stable while stalled; exactly 10 handshakes.
4. Stop with simultaneous write.
   - Stimulus: write addr 5=0x0AA in the same cycle as stop_flag with stop_addr=5.
   - Required response: replay last word=0x0AA.
5. Abort mid-replay.
   - Stimulus: arm asserted after 3 handshakes of scenario 2.
   - Required response: rd_valid=0 the next cycle; state_o=1; wrapped=0.
6. Reset mid-capture.
   - Stimulus: trig_rst for 1 cycle during CAPTURE.
   - Required response: state_o=0, rd_valid=0, wrapped=0 the next cycle; rd_start without arm is ignored.
